// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS sequencer: state encodings, opcodes,
// datapath select codes and the per-state control word decode.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ERROR     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG       = 2'b00;
    localparam logic [1:0] SRCB_FOUR      = 2'b01;
    localparam logic [1:0] SRCB_IMM       = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHIFT = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memtoReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSrc;
        logic       pcWrite;
        logic       branch;
        logic       instrDone;
        logic       error;
    } ctrl_t;

    // Moore decode: the control word depends on the state alone
    function automatic ctrl_t decodeState(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memRead = 1'b1;
                c.irWrite = 1'b1;
                c.aluSrcB = SRCB_FOUR;
                c.pcWrite = 1'b1;
            end
            S_DECODE:    c.aluSrcB = SRCB_IMM_SHIFT;
            S_MEM_ADDR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
            end
            S_MEM_WB: begin
                c.memtoReg  = 1'b1;
                c.regWrite  = 1'b1;
                c.instrDone = 1'b1;
            end
            S_MEM_WRITE: begin
                c.memWrite  = 1'b1;
                c.iorD      = 1'b1;
                c.instrDone = 1'b1;
            end
            S_EXECUTE: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                c.regDst    = 1'b1;
                c.regWrite  = 1'b1;
                c.instrDone = 1'b1;
            end
            S_BRANCH: begin
                c.aluSrcA   = 1'b1;
                c.aluOp     = ALUOP_SUB;
                c.pcSrc     = PCSRC_ALUOUT;
                c.branch    = 1'b1;
                c.instrDone = 1'b1;
            end
            S_JUMP: begin
                c.pcSrc     = PCSRC_JUMP;
                c.pcWrite   = 1'b1;
                c.instrDone = 1'b1;
            end
            S_ERROR:     c.error = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer. Outputs are registered from the next-state
// decode so every enable is glitch-free for the whole state cycle.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       InstrDone,
    output logic       Error,
    output logic [3:0] State
);

    state_t state;
    state_t nextState;
    ctrl_t  ctrl;
    logic   isLoad;

    // State, control word and the lw/sw flag captured while the opcode is valid
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            ctrl   <= '0;
            isLoad <= 1'b0;
        end else begin
            state <= nextState;
            ctrl  <= decodeState(nextState);
            if (state == S_DECODE && (Opcode == OP_LW || Opcode == OP_SW)) begin
                isLoad <= (Opcode == OP_LW);
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:      nextState = S_FETCH;
            S_FETCH:     nextState = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_R:         nextState = S_EXECUTE;
                    OP_LW, OP_SW: nextState = S_MEM_ADDR;
                    OP_BEQ:       nextState = S_BRANCH;
                    OP_J:         nextState = S_JUMP;
                    default:      nextState = HALT_ON_ILLEGAL ? S_ERROR : S_FETCH;
                endcase
            end
            S_MEM_ADDR:  nextState = isLoad ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  nextState = S_MEM_WB;
            S_MEM_WB:    nextState = S_FETCH;
            S_MEM_WRITE: nextState = S_FETCH;
            S_EXECUTE:   nextState = S_ALU_WB;
            S_ALU_WB:    nextState = S_FETCH;
            S_BRANCH:    nextState = S_FETCH;
            S_JUMP:      nextState = S_FETCH;
            S_ERROR:     nextState = S_ERROR;
            default:     nextState = S_IDLE;
        endcase
    end

    assign IorD      = ctrl.iorD;
    assign MemRead   = ctrl.memRead;
    assign MemWrite  = ctrl.memWrite;
    assign IRWrite   = ctrl.irWrite;
    assign RegDst    = ctrl.regDst;
    assign MemtoReg  = ctrl.memtoReg;
    assign RegWrite  = ctrl.regWrite;
    assign ALUSrcA   = ctrl.aluSrcA;
    assign ALUSrcB   = ctrl.aluSrcB;
    assign ALUOp     = ctrl.aluOp;
    assign PCSrc     = ctrl.pcSrc;
    assign InstrDone = ctrl.instrDone;
    assign Error     = ctrl.error;
    assign State     = state;

    // Branch resolution is the only path allowed to see Zero combinationally
    assign PCEn = ctrl.pcWrite | (ctrl.branch & Zero);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed vector table, corner sequences and
// randomized opcodes checked against an instruction-path reference model.
module tb_multicycle_control_fsm;

    logic       clock;
    logic       reset;
    logic [5:0] Opcode;
    logic       Zero;

    logic       hIorD, hMemRead, hMemWrite, hIRWrite, hRegDst, hMemtoReg, hRegWrite, hALUSrcA;
    logic [1:0] hALUSrcB, hALUOp, hPCSrc;
    logic       hPCEn, hInstrDone, hError;
    logic [3:0] hState;

    logic       nIorD, nMemRead, nMemWrite, nIRWrite, nRegDst, nMemtoReg, nRegWrite, nALUSrcA;
    logic [1:0] nALUSrcB, nALUOp, nPCSrc;
    logic       nPCEn, nInstrDone, nError;
    logic [3:0] nState;

    int assertCount = 0;
    int failCount   = 0;

    multicycle_control_fsm #(.HALT_ON_ILLEGAL(1'b1)) dutHalt (
        .clock(clock), .reset(reset), .Opcode(Opcode), .Zero(Zero),
        .IorD(hIorD), .MemRead(hMemRead), .MemWrite(hMemWrite), .IRWrite(hIRWrite),
        .RegDst(hRegDst), .MemtoReg(hMemtoReg), .RegWrite(hRegWrite), .ALUSrcA(hALUSrcA),
        .ALUSrcB(hALUSrcB), .ALUOp(hALUOp), .PCSrc(hPCSrc), .PCEn(hPCEn),
        .InstrDone(hInstrDone), .Error(hError), .State(hState)
    );

    multicycle_control_fsm #(.HALT_ON_ILLEGAL(1'b0)) dutNop (
        .clock(clock), .reset(reset), .Opcode(Opcode), .Zero(Zero),
        .IorD(nIorD), .MemRead(nMemRead), .MemWrite(nMemWrite), .IRWrite(nIRWrite),
        .RegDst(nRegDst), .MemtoReg(nMemtoReg), .RegWrite(nRegWrite), .ALUSrcA(nALUSrcA),
        .ALUSrcB(nALUSrcB), .ALUOp(nALUOp), .PCSrc(nPCSrc), .PCEn(nPCEn),
        .InstrDone(nInstrDone), .Error(nError), .State(nState)
    );

    logic [21:0] outH, outN;
    assign outH = {hIorD, hMemRead, hMemWrite, hIRWrite, hRegDst, hMemtoReg, hRegWrite, hALUSrcA,
                   hALUSrcB, hALUOp, hPCSrc, hPCEn, hInstrDone, hError, hState};
    assign outN = {nIorD, nMemRead, nMemWrite, nIRWrite, nRegDst, nMemtoReg, nRegWrite, nALUSrcA,
                   nALUSrcB, nALUOp, nPCSrc, nPCEn, nInstrDone, nError, nState};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: each decoded instruction expands into the list of states it visits
    int modelState [2];
    int pathQ [2][$];

    function automatic void advanceModel(input int k, input bit halt, input bit rst, input logic [5:0] op);
        if (rst) begin
            modelState[k] = 0;
            pathQ[k].delete();
        end else if (modelState[k] == 11) begin
            modelState[k] = 11;
        end else if (modelState[k] == 0) begin
            modelState[k] = 1;
        end else if (modelState[k] == 1) begin
            modelState[k] = 2;
        end else begin
            if (modelState[k] == 2) begin
                pathQ[k].delete();
                if (op == 6'd35)      pathQ[k] = '{3, 4, 5};
                else if (op == 6'd43) pathQ[k] = '{3, 6};
                else if (op == 6'd0)  pathQ[k] = '{7, 8};
                else if (op == 6'd4)  pathQ[k] = '{9};
                else if (op == 6'd2)  pathQ[k] = '{10};
                else if (halt)        pathQ[k] = '{11};
            end
            if (pathQ[k].size() > 0) modelState[k] = pathQ[k].pop_front();
            else                     modelState[k] = 1;
        end
    endfunction

    function automatic logic [21:0] expectedOutputs(input int s, input bit z);
        logic [1:0] srcB, aluOp, pcSrc;
        logic [3:0] st;
        logic pcEn, done;
        srcB  = (s == 1) ? 2'b01 : (s == 2) ? 2'b11 : (s == 3) ? 2'b10 : 2'b00;
        aluOp = (s == 7) ? 2'b10 : (s == 9) ? 2'b01 : 2'b00;
        pcSrc = (s == 9) ? 2'b01 : (s == 10) ? 2'b10 : 2'b00;
        pcEn  = (s == 1) || (s == 10) || (s == 9 && z);
        done  = (s == 5) || (s == 6) || (s == 8) || (s == 9) || (s == 10);
        st    = s[3:0];
        return {(s == 4 || s == 6), (s == 1 || s == 4), (s == 6), (s == 1), (s == 8), (s == 5),
                (s == 5 || s == 8), (s == 3 || s == 7 || s == 9), srcB, aluOp, pcSrc,
                pcEn, done, (s == 11), st};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock: drive inputs, step the model, then compare both instances after the edge
    task automatic applyStimulus(input bit rst, input logic [5:0] op, input bit z);
        reset  = rst;
        Opcode = op;
        Zero   = z;
        advanceModel(0, 1'b1, rst, op);
        advanceModel(1, 1'b0, rst, op);
        @(posedge clock);
        #1;
        checkOutput("haltOutputs", {10'd0, outH}, {10'd0, expectedOutputs(modelState[0], z)});
        checkOutput("nopOutputs",  {10'd0, outN}, {10'd0, expectedOutputs(modelState[1], z)});
        checkOutput("haltMemExcl", {31'd0, hMemRead & hMemWrite}, 32'd0);
        checkOutput("nopMemExcl",  {31'd0, nMemRead & nMemWrite}, 32'd0);
    endtask

    typedef struct {
        bit         rst;
        logic [5:0] op;
        bit         z;
        int         stH;
        int         stN;
        bit         pcEnH;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input bit rst, input logic [5:0] op, input bit z,
                                   input int stH, input int stN, input bit pcEnH);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.stH = stH; v.stN = stN; v.pcEnH = pcEnH;
        vecs.push_back(v);
    endfunction

    initial begin
        reset  = 1'b1;
        Opcode = 6'd0;
        Zero   = 1'b0;
        modelState[0] = 0;
        modelState[1] = 0;

        // rst, opcode, zero, expected State (halt/nop), expected PCEn (halt)
        addVec(1, 0,  0, 0, 0, 0);
        addVec(1, 0,  0, 0, 0, 0);
        addVec(0, 0,  0, 1, 1, 1);
        addVec(0, 0,  0, 2, 2, 0);
        addVec(0, 35, 0, 3, 3, 0);
        addVec(0, 0,  0, 4, 4, 0);
        addVec(0, 0,  0, 5, 5, 0);
        addVec(0, 0,  0, 1, 1, 1);
        addVec(0, 0,  0, 2, 2, 0);
        addVec(0, 43, 0, 3, 3, 0);
        addVec(0, 0,  0, 6, 6, 0);
        addVec(0, 0,  0, 1, 1, 1);
        addVec(0, 0,  0, 2, 2, 0);
        addVec(0, 4,  1, 9, 9, 1);
        addVec(0, 0,  0, 1, 1, 1);
        addVec(0, 0,  0, 2, 2, 0);
        addVec(0, 4,  0, 9, 9, 0);
        addVec(0, 0,  0, 1, 1, 1);
        addVec(0, 0,  0, 2, 2, 0);
        addVec(0, 0,  0, 7, 7, 0);
        addVec(0, 0,  0, 8, 8, 0);
        addVec(0, 0,  0, 1, 1, 1);
        addVec(0, 0,  0, 2, 2, 0);
        addVec(0, 2,  0, 10, 10, 1);
        addVec(0, 0,  0, 1, 1, 1);
        addVec(0, 0,  0, 2, 2, 0);
        addVec(0, 63, 0, 11, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].z);
            checkOutput("vecStateHalt", {28'd0, hState}, vecs[i].stH);
            checkOutput("vecStateNop",  {28'd0, nState}, vecs[i].stN);
            checkOutput("vecPCEnHalt",  {31'd0, hPCEn},  {31'd0, vecs[i].pcEnH});
        end

        // ERROR is sticky and silent regardless of opcode and Zero
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
            checkOutput("errHoldState", {28'd0, hState}, 32'd11);
            checkOutput("errHoldFlag",  {31'd0, hError}, 32'd1);
            checkOutput("errHoldEnables",
                        {28'd0, hMemRead, hMemWrite, hRegWrite, hPCEn}, 32'd0);
        end

        // Reset arriving in MEM_WRITE abandons the store at the very next edge
        applyStimulus(1'b1, 6'd0, 1'b0);
        applyStimulus(1'b0, 6'd0, 1'b0);
        applyStimulus(1'b0, 6'd0, 1'b0);
        applyStimulus(1'b0, 6'd43, 1'b0);
        applyStimulus(1'b0, 6'd0, 1'b0);
        checkOutput("swMemWriteHigh", {31'd0, hMemWrite}, 32'd1);
        checkOutput("swStateMemWrite", {28'd0, hState}, 32'd6);
        applyStimulus(1'b1, 6'd0, 1'b0);
        checkOutput("rstMemWriteLow", {31'd0, hMemWrite}, 32'd0);
        checkOutput("rstStateIdle", {28'd0, hState}, 32'd0);
        applyStimulus(1'b0, 6'd0, 1'b0);
        checkOutput("rstThenFetch", {28'd0, hState}, 32'd1);
        checkOutput("rstFetchIRWrite", {31'd0, hIRWrite}, 32'd1);

        // Randomized opcodes, mostly legal, with occasional resets
        for (int i = 0; i < 600; i++) begin
            logic [5:0] op;
            int pick;
            pick = $urandom_range(0, 11);
            case (pick)
                0, 1:    op = 6'd0;
                2, 3:    op = 6'd35;
                4, 5:    op = 6'd43;
                6, 7:    op = 6'd4;
                8, 9:    op = 6'd2;
                default: op = 6'($urandom_range(0, 63));
            endcase
            applyStimulus($urandom_range(0, 29) == 0, op, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multicycle sequencer for the MIPS datapath: one Moore state machine that walks each instruction through fetch, decode, execute, memory and write-back over 3–5 clock cycles. It shares the single `Memory` between instruction fetch and data access, and it drives the `ALU` and `RegFile` enables. It replaces the fixed `RegWrite = 1` of the single-cycle `ControlUnit`. `ALUOp` feeds the existing `ALUDecoder` unchanged.

## Interface
- `HALT_ON_ILLEGAL`, 1 — 1: an unknown opcode enters ERROR (sticky); 0: it is treated as a NOP and the FSM returns to FETCH.
- `clock`  in  1  — single clock; all state changes on posedge.
- `reset`  in  1  — synchronous, active-high.
- `Opcode`  in  6  — IR[31:26]; sampled in DECODE only.
- `Zero`  in  1  — ALU zero flag; used in BRANCH only.
- `IorD`  out  1  — memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`  out  1  — Memory `ren`.
- `MemWrite`  out  1  — Memory `wen`.
- `IRWrite`  out  1  — instruction register load.
- `RegDst`  out  1  — write-register select: 0 = rt, 1 = rd.
- `MemtoReg`  out  1  — write-data select: 0 = ALUOut, 1 = MDR.
- `RegWrite`  out  1  — RegFile `wen`.
- `ALUSrcA`  out  1  — ALU A select: 0 = PC, 1 = register A.
- `ALUSrcB`  out  2  — ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `ALUOp`  out  2  — 00 = add, 01 = sub, 10 = funct.
- `PCSrc`  out  2  — PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `PCEn`  out  1  — PC load = PCWrite | (Branch & `Zero`).
- `InstrDone`  out  1  — one-cycle pulse in the final state of each instruction.
- `Error`  out  1  — high in ERROR.
- `State`  out  4  — current state, for debug.

## Operation
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXECUTE 7, ALU_WB 8, BRANCH 9, JUMP 10, ERROR 11.
- Transitions:
  - IDLE → FETCH → DECODE.
  - DECODE by `Opcode`: 0 → EXECUTE; 35 (lw) or 43 (sw) → MEM_ADDR; 4 (beq) → BRANCH; 2 (j) → JUMP; any other → ERROR, or → FETCH if `HALT_ON_ILLEGAL` = 0.
  - MEM_ADDR → MEM_READ (lw) or MEM_WRITE (sw), using the opcode latched in DECODE.
  - MEM_READ → MEM_WB → FETCH.
  - MEM_WRITE → FETCH.
  - EXECUTE → ALU_WB → FETCH.
  - BRANCH → FETCH; JUMP → FETCH.
  - ERROR → ERROR until reset.
- Asserted outputs per state (any output not listed is 0):
  - FETCH: MemRead, IRWrite, ALUSrcB = 01, PCWrite.
  - DECODE: ALUSrcB = 11 (computes the branch target).
  - MEM_ADDR: ALUSrcA, ALUSrcB = 10.
  - MEM_READ: MemRead, IorD.
  - MEM_WB: MemtoReg, RegWrite.
  - MEM_WRITE: MemWrite, IorD.
  - EXECUTE: ALUSrcA, ALUOp = 10.
  - ALU_WB: RegDst, RegWrite.
  - BRANCH: ALUSrcA, ALUOp = 01, PCSrc = 01, Branch.
  - JUMP: PCSrc = 10, PCWrite.
  - ERROR: Error.
- `InstrDone` is high in MEM_WB, MEM_WRITE, ALU_WB, BRANCH and JUMP.
- `MemRead` and `MemWrite` are never high together in any state.

## Timing
- Reset: when `reset` = 1 at a posedge, the next state is IDLE and every output, including `State`, is 0.
  - The first posedge with `reset` = 0 moves the FSM to FETCH.
  - The same rule applies mid-instruction; any partial instruction is abandoned.
- Outputs come from a registered decode of the next state: they change only at posedge clock, are glitch-free, and are valid for the whole state cycle.
  - Required because `Memory` writes on `wen` level and `RegFile` writes on negedge.
  - Only `PCEn` is combinational, through `Zero`.
- Latency, counted from FETCH entry to the next FETCH entry:
  - lw: 5 cycles.
  - sw, R-type: 4 cycles.
  - beq, j: 3 cycles.
- `RegWrite` is held for the full write-back cycle, so the RegFile negedge write lands mid-cycle.

## Structure
- Shared package/header (`constants.h`) holds:
  - State encodings.
  - Opcodes: R 0, J 2, BEQ 4, LW 35, SW 43.
  - `ALUOp`, `ALUSrcB` and `PCSrc` codes.
- Single module; no sub-modules.
- One internal register latches lw/sw in DECODE.

## Test plan
- Reset held for 2 cycles → all outputs 0, `State` = 0; release → FETCH with MemRead = IRWrite = PCEn = 1.
- `Opcode` = 35 → state sequence 1, 2, 3, 4, 5, 1; MemRead and IorD high in state 4; RegWrite and MemtoReg high in state 5; `InstrDone` high in state 5 only.
- `Opcode` = 43 → sequence 1, 2, 3, 6, 1; MemWrite high exactly one cycle; RegWrite never high.
- `Opcode` = 4: with `Zero` = 1 in BRANCH → PCEn = 1 and PCSrc = 01; with `Zero` = 0 → PCEn = 0; both return to FETCH.
- `Opcode` = 63: with `HALT_ON_ILLEGAL` = 1 → ERROR held for 10 cycles with `Error` = 1 and all enables 0; with `HALT_ON_ILLEGAL` = 0 → back to FETCH.
- `reset` pulsed during MEM_WRITE → `MemWrite` low at the next posedge, then IDLE, then FETCH; assert that MemRead & MemWrite is never 1 over the whole run.
